// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter in front of a fixed-latency line memory.
// Default policy gives the data side priority; define ARB_ROUND_ROBIN_EN for round-robin.
`timescale 1ns/1ps
module mem_arbiter #(
   parameter int WIDTH   = 128,
   parameter int ADDR    = 32,
   parameter int LATENCY = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_req,
   input  logic             i_write,
   input  logic [ADDR-1:0]  i_addr,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             i_ack,
   output logic [WIDTH-1:0] i_rdata,
   input  logic             d_req,
   input  logic             d_write,
   input  logic [ADDR-1:0]  d_addr,
   input  logic [WIDTH-1:0] d_wdata,
   output logic             d_ack,
   output logic [WIDTH-1:0] d_rdata,
   output logic [ADDR-1:0]  mem_addr,
   output logic [WIDTH-1:0] mem_wdata,
   output logic             mem_read,
   output logic             mem_write,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_t           state_q;
   logic [3:0]       cnt_q;
   logic             gnt_d_q;
   logic [ADDR-1:0]  mem_addr_q;
   logic [WIDTH-1:0] mem_wdata_q;
   logic             mem_read_q;
   logic             mem_write_q;
   logic             i_ack_q;
   logic             d_ack_q;
   logic [WIDTH-1:0] i_rdata_q;
   logic [WIDTH-1:0] d_rdata_q;
   logic             busy_q;

   logic             gnt_d_d;
   logic [ADDR-1:0]  sel_addr_d;
   logic [WIDTH-1:0] sel_wdata_d;
   logic             sel_write_d;

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d_q;   // 1: data side was granted most recently
`endif

   always_comb begin
      gnt_d_d = d_req;
`ifdef ARB_ROUND_ROBIN_EN
      if (i_req && d_req) gnt_d_d = ~last_d_q;
`endif
      sel_addr_d  = gnt_d_d ? d_addr  : i_addr;
      sel_wdata_d = gnt_d_d ? d_wdata : i_wdata;
      sel_write_d = gnt_d_d ? d_write : i_write;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         // NOTE: datapath registers are cleared as well, so mem_addr and both rdata ports read zero after reset.
         state_q     <= IDLE;
         cnt_q       <= '0;
         gnt_d_q     <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
         busy_q      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (i_req || d_req) begin
                  gnt_d_q     <= gnt_d_d;
                  mem_addr_q  <= sel_addr_d;
                  mem_wdata_q <= sel_wdata_d;
                  mem_read_q  <= ~sel_write_d;
                  mem_write_q <= sel_write_d;
                  cnt_q       <= CNT_LOAD;
                  busy_q      <= 1'b1;
                  state_q     <= ACCESS;
`ifdef ARB_ROUND_ROBIN_EN
                  last_d_q    <= gnt_d_d;
`endif
               end
            end
            ACCESS: begin
               if (cnt_q == 4'd0) begin
                  if (mem_read_q) begin
                     if (gnt_d_q) d_rdata_q <= mem_rdata;
                     else         i_rdata_q <= mem_rdata;
                  end
                  mem_read_q  <= 1'b0;
                  mem_write_q <= 1'b0;
                  i_ack_q     <= ~gnt_d_q;
                  d_ack_q     <= gnt_d_q;
                  state_q     <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               i_ack_q <= 1'b0;
               d_ack_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: randomized two-sided traffic against a queue-based
// reference model, a mid-transaction reset, and a LATENCY=1 back-to-back instance.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int WIDTH = 128;
   localparam int ADDR  = 32;
   localparam int LAT   = 4;
   localparam int MEM_N = 64;

   typedef struct {
      bit               side_d;
      bit               wr;
      logic [ADDR-1:0]  addr;
      logic [WIDTH-1:0] rdata;
      int               cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset;
   logic             i_req, i_write, d_req, d_write;
   logic [ADDR-1:0]  i_addr, d_addr;
   logic [WIDTH-1:0] i_wdata, d_wdata;
   logic             i_ack, d_ack;
   logic [WIDTH-1:0] i_rdata, d_rdata;
   logic [ADDR-1:0]  mem_addr;
   logic [WIDTH-1:0] mem_wdata, mem_rdata;
   logic             mem_read, mem_write, busy;

   logic             l1_i_req, l1_i_write, l1_d_req, l1_d_write;
   logic [ADDR-1:0]  l1_i_addr, l1_d_addr;
   logic [WIDTH-1:0] l1_i_wdata, l1_d_wdata;
   logic             l1_i_ack, l1_d_ack;
   logic [WIDTH-1:0] l1_i_rdata, l1_d_rdata;
   logic [ADDR-1:0]  l1_mem_addr;
   logic [WIDTH-1:0] l1_mem_wdata, l1_mem_rdata;
   logic             l1_mem_read, l1_mem_write, l1_busy;

   mem_arbiter #(.WIDTH(WIDTH), .ADDR(ADDR), .LATENCY(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
      .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
      .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_arbiter #(.WIDTH(WIDTH), .ADDR(ADDR), .LATENCY(1)) u_lat1 (
      .clk(clk), .reset(reset),
      .i_req(l1_i_req), .i_write(l1_i_write), .i_addr(l1_i_addr), .i_wdata(l1_i_wdata),
      .i_ack(l1_i_ack), .i_rdata(l1_i_rdata),
      .d_req(l1_d_req), .d_write(l1_d_write), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
      .d_ack(l1_d_ack), .d_rdata(l1_d_rdata),
      .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata), .mem_read(l1_mem_read),
      .mem_write(l1_mem_write), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
   );

   function automatic logic [WIDTH-1:0] init_val(input int i);
      if (i == 16) return WIDTH'(128'hA5);
      return {32'(i) * 32'h9E37_79B9, ~32'(i), 32'(i) ^ 32'h5555_5555, 32'hC0FF_EE00 + 32'(i)};
   endfunction

   function automatic logic [WIDTH-1:0] l1_pat(input logic [ADDR-1:0] a);
      return {{(WIDTH-ADDR){1'b0}}, a} ^ {(WIDTH/32){32'h5A5A_0F0F}};
   endfunction

   function automatic logic [WIDTH-1:0] rand_line();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Backing memory: combinational read, written on each edge the write strobe is up.
   logic [WIDTH-1:0] mem [MEM_N];
   assign mem_rdata    = mem[mem_addr[5:0]];
   assign l1_mem_rdata = l1_pat(l1_mem_addr);

   initial begin
      for (int i = 0; i < MEM_N; i++) mem[i] = init_val(i);
      forever begin
         @(posedge clk);
         if (mem_write) mem[mem_addr[5:0]] <= mem_wdata;
      end
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state.
   logic [WIDTH-1:0] ref_mem [MEM_N];
   logic [WIDTH-1:0] last_rd_i, last_rd_d;
   bit               rr_last_d;
   exp_t             sb[$];

   int n_cmp = 0;
   int n_err = 0;
   bit mon_en = 1'b1;

   task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor: pops the scoreboard whenever an ack appears.
   int   strobe_cnt = 0;
   exp_t mon_e;
   initial begin
      forever begin
         @(negedge clk);
         if (!reset || !mon_en) begin
            strobe_cnt = 0;
         end else begin
            if (mem_read || mem_write) begin
               strobe_cnt++;
               if (sb.size() == 0) fail("strobe_without_request");
               else begin
                  check("mem_addr", WIDTH'(mem_addr), WIDTH'(sb[0].addr));
                  check("mem_write", WIDTH'(mem_write), WIDTH'(sb[0].wr));
               end
            end
            if (i_ack && d_ack) fail("both_acks_high");
            else if (i_ack || d_ack) begin
               if (sb.size() == 0) fail("unexpected_ack");
               else begin
                  mon_e = sb.pop_front();
                  check("ack_side", WIDTH'(d_ack), WIDTH'(mon_e.side_d));
                  check("ack_cycle", WIDTH'(cyc), WIDTH'(mon_e.cyc));
                  check("rdata", d_ack ? d_rdata : i_rdata, mon_e.rdata);
                  check("strobe_cycles", WIDTH'(strobe_cnt), WIDTH'(LAT));
                  check("busy_in_resp", WIDTH'(busy), WIDTH'(1));
               end
               strobe_cnt = 0;
            end
         end
      end
   end

   // One round: present up to one request per side at the same edge, predict order,
   // data and ack cycle, then play the requester handshake until both are acked.
   task automatic do_round(input bit ui, input bit iw, input logic [ADDR-1:0] ia,
                           input logic [WIDTH-1:0] iwd, input bit ud, input bit dw,
                           input logic [ADDR-1:0] da, input logic [WIDTH-1:0] dwd);
      bit   first_d, sd, pend_i, pend_d, ack_i_s, ack_d_s;
      int   k, n, t;
      exp_t e;
      if (!ui && !ud) return;
      if (ui && ud) begin
`ifdef ARB_ROUND_ROBIN_EN
         first_d = !rr_last_d;
`else
         first_d = 1'b1;
`endif
      end else begin
         first_d = ud;
      end
      k = cyc;
      n = (ui && ud) ? 2 : 1;
      for (int j = 0; j < n; j++) begin
         sd        = (j == 0) ? first_d : !first_d;
         rr_last_d = sd;
         e.side_d  = sd;
         e.wr      = sd ? dw : iw;
         e.addr    = sd ? da : ia;
         e.cyc     = k + 1 + LAT + j * (LAT + 2);
         if (e.wr) ref_mem[e.addr[5:0]] = sd ? dwd : iwd;
         else if (sd) last_rd_d = ref_mem[e.addr[5:0]];
         else         last_rd_i = ref_mem[e.addr[5:0]];
         e.rdata = sd ? last_rd_d : last_rd_i;
         sb.push_back(e);
      end
      i_req = ui; i_write = iw; i_addr = ia; i_wdata = iwd;
      d_req = ud; d_write = dw; d_addr = da; d_wdata = dwd;
      pend_i = ui;
      pend_d = ud;
      t = 0;
      while ((pend_i || pend_d) && t < 4 * LAT + 20) begin
         @(negedge clk);
         ack_i_s = i_ack;
         ack_d_s = d_ack;
         @(posedge clk);
         #1;
         t++;
         if (t == 1) begin
            // The first-served side has just been granted; its operands must no longer matter.
            if (first_d) begin d_addr = $urandom; d_wdata = rand_line(); d_write = $urandom; end
            else         begin i_addr = $urandom; i_wdata = rand_line(); i_write = $urandom; end
         end
         if (ack_i_s && pend_i) begin pend_i = 1'b0; i_req = 1'b0; end
         if (ack_d_s && pend_d) begin pend_d = 1'b0; d_req = 1'b0; end
      end
      if (pend_i || pend_d) begin
         fail("round_timeout");
         i_req = 1'b0;
         d_req = 1'b0;
         sb.delete();
      end
   endtask

   task automatic rand_round();
      do_round($urandom, $urandom, ADDR'($urandom_range(MEM_N-1, 0)), rand_line(),
               $urandom, $urandom, ADDR'($urandom_range(MEM_N-1, 0)), rand_line());
   endtask

   task automatic reset_abort_test();
      bit seen;
      mon_en = 1'b0;
      i_req = 1'b1; i_write = 1'b0; i_addr = 32'h5;
      @(posedge clk); #1;             // grant edge, first ACCESS cycle
      check("abort_busy_access", WIDTH'(busy), WIDTH'(1));
      @(posedge clk); #1;             // second ACCESS cycle
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      i_req = 1'b0;
      check("abort_mem_read", WIDTH'(mem_read), WIDTH'(0));
      check("abort_busy", WIDTH'(busy), WIDTH'(0));
      check("abort_i_ack", WIDTH'(i_ack), WIDTH'(0));
      check("abort_i_rdata", i_rdata, '0);
      seen = 1'b0;
      repeat (LAT + 4) begin
         @(negedge clk);
         if (i_ack || d_ack || mem_read || mem_write) seen = 1'b1;
      end
      check("abort_no_ack", WIDTH'(seen), WIDTH'(0));
      @(posedge clk); #1;
      last_rd_i = '0;
      last_rd_d = '0;
      rr_last_d = 1'b0;
      mon_en    = 1'b1;
   endtask

   task automatic lat1_test();
      logic [ADDR-1:0] a;
      int k;
      a = $urandom;
      l1_i_req = 1'b1; l1_i_write = 1'b0; l1_i_addr = a;
      k = cyc;
      for (int j = 0; j < 4; j++) begin
         @(posedge clk); #1;
         l1_i_addr = $urandom;         // change during ACCESS, must be ignored
         @(negedge clk);
         check("l1_ack_low_access", WIDTH'(l1_i_ack), WIDTH'(0));
         @(posedge clk);
         @(negedge clk);
         check("l1_ack", WIDTH'(l1_i_ack), WIDTH'(1));
         check("l1_ack_cycle", WIDTH'(cyc), WIDTH'(k + 2 + 3 * j));
         check("l1_rdata", l1_i_rdata, l1_pat(a));
         check("l1_d_ack", WIDTH'(l1_d_ack), WIDTH'(0));
         @(posedge clk); #1;
         a = $urandom;
         l1_i_addr = a;
         if (j == 3) l1_i_req = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog_expired (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      i_req = 1'b0; i_write = 1'b0; i_addr = '0; i_wdata = '0;
      d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
      l1_i_req = 1'b0; l1_i_write = 1'b0; l1_i_addr = '0; l1_i_wdata = '0;
      l1_d_req = 1'b0; l1_d_write = 1'b0; l1_d_addr = '0; l1_d_wdata = '0;
      for (int i = 0; i < MEM_N; i++) ref_mem[i] = init_val(i);
      last_rd_i = '0;
      last_rd_d = '0;
      rr_last_d = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", WIDTH'(busy), WIDTH'(0));
      check("rst_mem_read", WIDTH'(mem_read), WIDTH'(0));
      check("rst_mem_write", WIDTH'(mem_write), WIDTH'(0));
      check("rst_i_ack", WIDTH'(i_ack), WIDTH'(0));
      check("rst_d_ack", WIDTH'(d_ack), WIDTH'(0));
      check("rst_mem_addr", WIDTH'(mem_addr), '0);
      check("rst_mem_wdata", mem_wdata, '0);
      check("rst_i_rdata", i_rdata, '0);
      check("rst_d_rdata", d_rdata, '0);
      reset = 1'b1;
      @(posedge clk); #1;

      do_round(1'b1, 1'b0, 32'h10, '0, 1'b0, 1'b0, '0, '0);              // i read 0x10 -> 0xA5
      do_round(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h20, WIDTH'(16'h1234)); // d write 0x20
      do_round(1'b1, 1'b0, 32'h20, '0, 1'b0, 1'b0, '0, '0);              // read back 0x1234
      do_round(1'b1, 1'b0, 32'h3, '0, 1'b1, 1'b0, 32'h7, '0);            // simultaneous
      repeat (3) do_round(1'b1, $urandom, ADDR'($urandom_range(MEM_N-1, 0)), rand_line(),
                          1'b1, $urandom, ADDR'($urandom_range(MEM_N-1, 0)), rand_line());

      repeat (60) begin
         rand_round();
         repeat ($urandom_range(2, 0)) begin @(posedge clk); #1; end
      end

      reset_abort_test();
      repeat (10) rand_round();

      lat1_test();
      repeat (2) @(posedge clk);
      if (sb.size() != 0) fail("scoreboard_not_empty");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, 128, line width in bits of the backing memory and of every data port.
REQ-002 Parameter ADDR, 32, address width in bits.
REQ-003 Parameter LATENCY, 4, memory access time in cycles; legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 i_req, i_write  input  1 each  instruction-side request and write qualifier.
REQ-007 i_addr  input  ADDR  instruction-side address.
REQ-008 i_wdata  input  WIDTH  instruction-side write data.
REQ-009 i_ack  output  1  instruction-side completion pulse.
REQ-010 i_rdata  output  WIDTH  instruction-side read data.
REQ-011 d_req, d_write, d_addr, d_wdata, d_ack, d_rdata  mirror REQ-006..REQ-010 for the data side.
REQ-012 mem_addr  output  ADDR  address to the memory.
REQ-013 mem_wdata  output  WIDTH  write data to the memory.
REQ-014 mem_read, mem_write  output  1 each  memory strobes.
REQ-015 mem_rdata  input  WIDTH  combinational read data from the memory.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCESS and RESP, with one transaction in flight at a time.
REQ-018 IDLE with any req high: grant one requester, latch its addr/wdata/write into mem_* registers, assert mem_read (write=0) or mem_write (write=1), load the counter with LATENCY-1, and go to ACCESS.
REQ-019 ACCESS: hold mem_* stable and decrement the counter; when the counter is 0, capture mem_rdata into the granted side's rdata register (reads only), drop mem_read/mem_write, and go to RESP.
REQ-020 RESP: assert the granted side's ack for exactly one cycle, then go to IDLE; the non-granted ack SHALL stay 0.
REQ-021 Latency: a req sampled in IDLE at edge N SHALL produce ack high in the cycle after edge N+LATENCY.
REQ-022 Requesters hold req and operands stable until ack and drop req at the edge that ends the ack cycle; the arbiter SHALL NOT re-sample req during ACCESS or RESP.
REQ-023 Changes to a requester's operands after grant SHALL NOT affect the transaction in flight.
REQ-024 i_rdata and d_rdata SHALL hold their value until the next read ack on the same side; writes SHALL leave them unchanged.
REQ-025 Fixed policy (default), both req high in IDLE: grant the data side.
REQ-026 A request that loses arbitration SHALL be served in the next IDLE in which it is still asserted.

Reset
REQ-027 With reset low at an edge, the block SHALL enter IDLE, clear the counter, drive mem_read=0, mem_write=0, i_ack=0, d_ack=0 and busy=0, and zero mem_addr, mem_wdata, i_rdata and d_rdata.
REQ-028 Reset asserted mid-transaction SHALL abort it with no ack, and the strobes SHALL be low from the following cycle.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN defined: a last-grant pointer resets to instruction side; on conflict the grant goes to the side not last granted, and the pointer updates on every grant.
REQ-030 Macro ARB_ROUND_ROBIN_EN undefined: the fixed data-priority policy of REQ-025 applies and no pointer exists.

Verification
REQ-031 LATENCY=4, single i_req read of addr 0x10 with memory returning 0xA5 -> mem_read high for 4 cycles, i_ack 1 cycle later, i_rdata=0xA5, d_ack never high.
REQ-032 d_req write of addr 0x20 with data 0x1234 -> mem_write high 4 cycles with mem_addr=0x20, then d_ack, and a subsequent read of 0x20 returns 0x1234.
REQ-033 i_req and d_req high in the same cycle, fixed policy -> data served first; instruction ack arrives 11 cycles after the request.
REQ-034 ARB_ROUND_ROBIN_EN, both sides requesting continuously for 4 transactions -> grants alternate in the order D, I, D, I.
REQ-035 Reset driven low in the 2nd ACCESS cycle -> no ack, mem_read=0 next cycle, busy=0, and a fresh request completes normally.
REQ-036 LATENCY=1 back-to-back reads -> ack every 3 cycles, with addr changes made during ACCESS ignored.
